divide_ramp_ctrl: RTL
=====================

// Module: divide_ramp_ctrl
// PURPOSE
//  Upstream stage of the integer clock divider. Drives the divider's divide_in word.
//  Accepts a target ratio over a valid/ready handshake and slews divide_out toward it.
//  Steps are at most req_step per hop, with a programmable dwell between hops.
//  The dwell lets the divider apply each ratio at a period boundary and avoids large frequency jumps.
// PARAMETERS
//  WIDTH     8    width of ratio words (divider uses 8)
//  DWELL     512  cycles divide_out is held after each hop; >= 2*(2^WIDTH) covers divider update latency
//  RESET_DIV 0    divide_out value after reset (0 = divider bypass, clock_out = clk)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst_n      in   1      synchronous, active-low reset
//  req_valid  in   1      new target request
//  req_ready  out  1      1 only in IDLE and rst_n high; transfer = req_valid & req_ready
//  req_target in   WIDTH  target ratio
//  req_step   in   WIDTH  max hop size; 0 treated as 1
//  abort      in   1      stop ramp, freeze divide_out at current value
//  divide_out out  WIDTH  ratio to divider divide_in (registered)
//  busy       out  1      1 in STEP/DWELL
//  done       out  1      one-cycle pulse: divide_out reached target
// BEHAVIOUR
//  Reset (rst_n low at posedge): state=IDLE, divide_out=RESET_DIV, done=0, busy=0,
//   latched target/step=0, dwell counter=0. Reset mid-ramp abandons the ramp. No done pulse.
//  State IDLE
//   - On transfer: latch tgt=req_target, stp=(req_step==0)?1:req_step.
//   - If tgt==divide_out: stay IDLE and pulse done next cycle.
//   - Otherwise go to STEP.
//   - req_valid outside IDLE is not accepted; the requester holds it.
//  State STEP (1 cycle)
//   - Up: divide_out <= min(divide_out+stp, tgt), computed in WIDTH+1 bits, no wrap.
//   - Down: divide_out <= max(divide_out-stp, tgt), computed signed, no underflow.
//   - Load cnt=DWELL-1; go to DWELL.
//  State DWELL
//   - cnt decrements each cycle.
//   - At cnt==0: if divide_out==tgt, go to IDLE and pulse done; else go to STEP.
//   - Each hop spans DWELL+1 cycles.
//  Timing: transfer at edge E0. divide_out first changes at E1. done is high for the cycle after the final dwell.
//  abort in STEP/DWELL: next edge state=IDLE, divide_out holds, cnt cleared, no done. abort beats STEP update. abort in IDLE is ignored and does not block a same-cycle transfer.
//  busy = (state!=IDLE), registered with state. done is never high together with busy.
//  divide_out changes only on STEP edges, never mid-dwell. At most one hop per DWELL+1 cycles.
// TESTING (DWELL=4 unless noted)
//  1 Reset: rst_n=0 three cycles -> divide_out=0, busy=0, done=0, req_ready=0. After release req_ready=1.
//  2 Up ramp 0->4, step 1 -> divide_out 1,2,3,4, each held 5 cycles. done is 1 cycle after the last dwell. busy is low thereafter.
//  3 Down ramp with clamp 10->3, step 4 -> divide_out 6, then 3 (clamped). done pulses once.
//  4 Overflow guard 250->255, step 10 -> single hop to 255, no wrap.
//  5 Equal target: req_target == divide_out=7 -> no change, done 1 cycle after transfer, busy stays 0.
//  6 Abort/reset mid-ramp 0->8: abort while divide_out=3 -> holds 3, IDLE, no done.
//     Re-request 8 -> resumes from 3. rst_n low mid-ramp -> divide_out=0.
//     Also check: req_valid held while busy is not accepted until IDLE.

Source files
------------

// File: rtl/divide_ramp_ctrl.sv
// Ratio slew controller for the integer clock divider: accepts a target ratio and
// walks divide_out toward it in bounded hops, holding each value for a dwell period.
module divide_ramp_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DWELL     = 512,
    parameter int RESET_DIV = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_target,
    input  logic [WIDTH-1:0] req_step,
    input  logic             abort,
    output logic [WIDTH-1:0] divide_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_DWELL
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] stp_q, stp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic                    xfer;
    logic [WIDTH:0]          up_sum;
    logic signed [WIDTH+1:0] dn_diff;
    logic [WIDTH-1:0]        hop_val;

    assign req_ready  = rst_n && (state_q == S_IDLE);
    assign xfer       = req_valid && req_ready;
    assign divide_out = div_q;
    assign busy       = busy_q;
    assign done       = done_q;

    // Extra headroom bits keep the up-sum from wrapping and the down-difference from going unsigned.
    always_comb begin
        up_sum  = {1'b0, div_q} + {1'b0, stp_q};
        dn_diff = $signed({2'b00, div_q}) - $signed({2'b00, stp_q});
        if (tgt_q > div_q) begin
            hop_val = (up_sum > {1'b0, tgt_q}) ? tgt_q : up_sum[WIDTH-1:0];
        end else begin
            hop_val = (dn_diff < $signed({2'b00, tgt_q})) ? tgt_q : dn_diff[WIDTH-1:0];
        end
    end

    always_comb begin
        // NOTE: every next-state value starts from its held value so no path can infer a latch.
        state_d = state_q;
        div_d   = div_q;
        tgt_d   = tgt_q;
        stp_d   = stp_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    tgt_d = req_target;
                    stp_d = (req_step == '0) ? WIDTH'(1) : req_step;
                    if (req_target == div_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    div_d   = hop_val;
                    cnt_d   = CNT_W'(DWELL - 1);
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (div_q == tgt_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_STEP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; all next values come from the comb block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= WIDTH'(RESET_DIV);
            tgt_q   <= '0;
            stp_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tgt_q   <= tgt_d;
            stp_q   <= stp_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
